// File: rtl/hilo_pkg.sv
// -----------------------------------------------------------------------------
// hilo_pkg
// Shared definitions for the HI/LO register unit and its iterative divider:
//   - hilo_en write-select codes (EN_LO / EN_HI / EN_NONE / EN_BOTH)
//   - hilo_mf read-select codes  (MF_LO / MF_HI)
//   - divider state encoding      (IDLE / BUSY / DONE)
//   - DIV_CYCLES: quotient bits produced, one per cycle (fixed at 32)
//   - abs32(): magnitude helper used when latching signed operands
// -----------------------------------------------------------------------------
package hilo_pkg;

    localparam int DIV_CYCLES = 32;

    typedef enum logic [1:0] {
        EN_LO   = 2'b00,
        EN_HI   = 2'b01,
        EN_NONE = 2'b10,
        EN_BOTH = 2'b11
    } hilo_en_e;

    typedef enum logic [1:0] {
        MF_LO = 2'b00,
        MF_HI = 2'b01
    } hilo_mf_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_e;

    // Two's-complement magnitude when the operand is treated as signed.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic use_sign);
        return (use_sign && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_div_unit_if.sv
// -----------------------------------------------------------------------------
// hilo_div_unit_if
// Execute-stage bundle between the pipeline and the HI/LO unit.
//   Pipeline -> unit : hilo_en[1:0], hilo_mf[1:0], div, hassign, src_a[31:0],
//                      src_b[31:0], prod[63:0], cancel
//   Unit -> pipeline : stall, div_done, mf_data[31:0], hi[31:0], lo[31:0]
// master = pipeline side, slave = hilo_div_unit.
// -----------------------------------------------------------------------------
interface hilo_div_unit_if;

    logic [1:0]  hilo_en;
    logic [1:0]  hilo_mf;
    logic        div;
    logic        hassign;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [63:0] prod;
    logic        cancel;
    logic        stall;
    logic        div_done;
    logic [31:0] mf_data;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output hilo_en, hilo_mf, div, hassign, src_a, src_b, prod, cancel,
        input  stall, div_done, mf_data, hi, lo
    );

    modport slave (
        input  hilo_en, hilo_mf, div, hassign, src_a, src_b, prod, cancel,
        output stall, div_done, mf_data, hi, lo
    );

endinterface

// File: rtl/hilo_div_unit_div_core.sv
// -----------------------------------------------------------------------------
// div_core
// Restoring radix-2 divider, one quotient bit per cycle.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           request; honoured only in IDLE
//   cancel          abort; returns to IDLE from any state
//   signed_op       1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
//   a, b            dividend / divisor; latched on the start edge only
//   done            high for the single DONE cycle
//   quo, rem        sign-corrected quotient / remainder, valid while done
// -----------------------------------------------------------------------------
module div_core #(
    parameter int DIV_CYCLES = hilo_pkg::DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cancel,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] quo,
    output logic [31:0] rem
);
    import hilo_pkg::*;

    localparam int CW = $clog2(DIV_CYCLES);

    div_state_e    state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [63:0]   acc_reg;      // {remainder, quotient/dividend}
    logic [31:0]   divisor_reg;
    logic          sign_a_reg;   // already gated by the signed flag
    logic          sign_b_reg;

    logic [32:0]   trial;
    logic [63:0]   acc_step;
    logic [31:0]   q_mag;
    logic [31:0]   r_mag;
    logic          div_zero;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (cnt_reg == CW'(DIV_CYCLES - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (cancel) begin
            state_next = IDLE;
        end
    end

    // ---------------- iteration step ----------------
    // After the left shift the partial remainder is acc_reg[63:31] (33 bits);
    // subtracting the zero-extended divisor leaves a negative result (bit 32
    // set) exactly when the trial fails.
    always_comb begin
        trial = acc_reg[63:31] - {1'b0, divisor_reg};
        if (trial[32]) begin
            acc_step = {acc_reg[62:0], 1'b0};
        end else begin
            acc_step = {trial[31:0], acc_reg[30:0], 1'b1};
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            acc_reg     <= '0;
            divisor_reg <= '0;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
        end else if (state_reg == IDLE && start && !cancel) begin
            cnt_reg     <= '0;
            acc_reg     <= {32'd0, abs32(a, signed_op)};
            divisor_reg <= abs32(b, signed_op);
            sign_a_reg  <= signed_op & a[31];
            sign_b_reg  <= signed_op & b[31];
        end else if (state_reg == BUSY) begin
            cnt_reg <= cnt_reg + 1'b1;
            acc_reg <= acc_step;
        end
    end

    // ---------------- sign fix ----------------
    // Divide by zero leaves the all-ones quotient untouched. The remainder is
    // still re-signed, which turns |a| back into the original dividend, so HI
    // ends up holding src_a in both modes.
    assign q_mag    = acc_reg[31:0];
    assign r_mag    = acc_reg[63:32];
    assign div_zero = (divisor_reg == 32'd0);

    assign quo  = ((sign_a_reg ^ sign_b_reg) && !div_zero) ? (~q_mag + 32'd1) : q_mag;
    assign rem  = sign_a_reg ? (~r_mag + 32'd1) : r_mag;
    assign done = (state_reg == DONE);

endmodule

// File: rtl/hilo_div_unit.sv
// -----------------------------------------------------------------------------
// hilo_div_unit
// Execute-stage HI/LO registers with an iterative 32-bit DIV/DIVU.
// Ports:
//   clk      sole clock, rising edge
//   rst_n    synchronous active-low reset
//   bus      hilo_div_unit_if.slave:
//              hilo_en  11 {HI,LO}<=prod, 01 HI<=src_a, 00 LO<=src_a, 10 none
//              hilo_mf  01 read HI, 00 read LO, else 0 (combinational mf_data)
//              div/hassign/src_a/src_b  divide request and operands
//              cancel   flush; aborts a division with no write
//              stall    div & ~DONE & ~cancel
//              div_done pulse on the cycle the quotient/remainder commit
//              hi/lo    current register values
// -----------------------------------------------------------------------------
module hilo_div_unit #(
    parameter int DIV_CYCLES = hilo_pkg::DIV_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    hilo_div_unit_if.slave   bus
);
    import hilo_pkg::*;

    logic [31:0] hi_reg, lo_reg;
    logic [31:0] hi_next, lo_next;
    logic        core_done;
    logic        commit;
    logic [31:0] core_quo, core_rem;
    logic        rd_hi, rd_lo;

    // The core ignores start outside IDLE, so div held high through BUSY and
    // DONE belongs to the same instruction and never restarts it.
    div_core #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (bus.div & ~bus.cancel),
        .cancel    (bus.cancel),
        .signed_op (bus.hassign),
        .a         (bus.src_a),
        .b         (bus.src_b),
        .done      (core_done),
        .quo       (core_quo),
        .rem       (core_rem)
    );

    // A flush in the DONE cycle also suppresses the commit.
    assign commit       = core_done & ~bus.cancel;
    assign bus.div_done = commit;
    assign bus.stall    = bus.div & ~core_done & ~bus.cancel;

    // ---------------- write-priority mux ----------------
    always_comb begin
        hi_next = hi_reg;
        lo_next = lo_reg;
        case (bus.hilo_en)
            EN_BOTH: {hi_next, lo_next} = bus.prod;
            EN_HI:   hi_next = bus.src_a;
            EN_LO:   lo_next = bus.src_a;
            default: ;
        endcase
        // Divider result overrides any concurrent hilo_en write.
        if (commit) begin
            hi_next = core_rem;
            lo_next = core_quo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else begin
            hi_reg <= hi_next;
            lo_reg <= lo_next;
        end
    end

    // ---------------- read mux (registered values only) ----------------
    assign rd_hi = (bus.hilo_mf == MF_HI);
    assign rd_lo = (bus.hilo_mf == MF_LO);

    for (genvar gi = 0; gi < 32; gi++) begin : g_mf
        assign bus.mf_data[gi] = (rd_hi & hi_reg[gi]) | (rd_lo & lo_reg[gi]);
    end

    assign bus.hi = hi_reg;
    assign bus.lo = lo_reg;

endmodule

// File: tb/tb_hilo_div_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_div_unit
// Directed bench for hilo_div_unit: inputs change 1 time unit after a rising
// edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_hilo_div_unit;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hilo_div_unit_if bus();

    hilo_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one division from IDLE (caller is 1 unit after a rising edge).
    // Returns at the falling edge of cycle 34 and checks stall length,
    // div_done position and the committed HI/LO.
    task automatic run_div(input string tag, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input logic en_in_done);
        int stall_cnt;
        int done_at;
        stall_cnt = 0;
        done_at   = -1;
        bus.div     = 1'b1;
        bus.hassign = sgn;
        bus.src_a   = a;
        bus.src_b   = b;
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            @(negedge clk);
            if (bus.stall === 1'b1) stall_cnt++;
            if (bus.div_done === 1'b1) begin
                done_at = c;
                if (en_in_done) begin
                    bus.hilo_en = 2'b11;
                    bus.prod    = 64'hAAAA_BBBB_CCCC_DDDD;
                end
            end
            step();
            if (c == 0) begin
                // Operands must already be latched.
                bus.src_a = 32'h1357_9BDF;
                bus.src_b = 32'h0000_0003;
            end
        end
        bus.div     = 1'b0;
        bus.hilo_en = 2'b10;
        @(negedge clk);
        check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'd33);
        check({tag, "_done_cycle"}, 64'(done_at), 64'd33);
        check({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
        check({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
        $display("[TB] %s a=%08h b=%08h signed=%0d -> lo=%08h hi=%08h done@%0d",
                 tag, a, b, sgn, bus.lo, bus.hi, done_at);
    endtask

    initial begin
        logic seen_done;

        rst_n       = 1'b0;
        bus.hilo_en = 2'b10;
        bus.hilo_mf = 2'b10;
        bus.div     = 1'b0;
        bus.hassign = 1'b0;
        bus.src_a   = '0;
        bus.src_b   = '0;
        bus.prod    = '0;
        bus.cancel  = 1'b0;

        // ---- reset state ----
        step();
        step();
        @(negedge clk);
        check("rst_hi", {32'd0, bus.hi}, 64'd0);
        check("rst_lo", {32'd0, bus.lo}, 64'd0);
        check("rst_stall", {63'd0, bus.stall}, 64'd0);
        check("rst_div_done", {63'd0, bus.div_done}, 64'd0);
        check("rst_mf_data", {32'd0, bus.mf_data}, 64'd0);
        $display("[TB] reset released");
        step();
        rst_n = 1'b1;

        // ---- MULT write: visible only after the edge ----
        bus.prod    = 64'h0000_0001_0000_0002;
        bus.hilo_en = 2'b11;
        @(negedge clk);
        check("mult_before_edge_hi", {32'd0, bus.hi}, 64'd0);
        step();
        bus.hilo_en = 2'b10;
        @(negedge clk);
        check("mult_hi", {32'd0, bus.hi}, 64'd1);
        check("mult_lo", {32'd0, bus.lo}, 64'd2);
        $display("[TB] MULT prod=%016h -> hi=%08h lo=%08h", bus.prod, bus.hi, bus.lo);

        // ---- MTHI ----
        step();
        bus.src_a   = 32'h0000_DEAD;
        bus.hilo_en = 2'b01;
        step();
        bus.hilo_en = 2'b10;
        @(negedge clk);
        check("mthi_hi", {32'd0, bus.hi}, 64'h0000_DEAD);
        check("mthi_lo_kept", {32'd0, bus.lo}, 64'd2);
        $display("[TB] MTHI %08h -> hi=%08h lo=%08h", 32'h0000_DEAD, bus.hi, bus.lo);

        // ---- MFHI / MFLO / undefined select ----
        bus.hilo_mf = 2'b01;
        #1 check("mfhi", {32'd0, bus.mf_data}, 64'h0000_DEAD);
        bus.hilo_mf = 2'b00;
        #1 check("mflo", {32'd0, bus.mf_data}, 64'd2);
        bus.hilo_mf = 2'b11;
        #1 check("mf_other", {32'd0, bus.mf_data}, 64'd0);
        bus.hilo_mf = 2'b10;
        $display("[TB] MFHI/MFLO read done");

        // ---- divisions ----
        step();
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        step();
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        step();
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        step();
        run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);
        step();
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);

        // ---- cancel at cycle 10 ----
        step();
        bus.div     = 1'b1;
        bus.hassign = 1'b0;
        bus.src_a   = 32'd100;
        bus.src_b   = 32'd7;
        for (int c = 0; c < 10; c++) step();
        check("cancel_stall_before", {63'd0, bus.stall}, 64'd1);
        bus.cancel = 1'b1;
        #1 check("cancel_stall_same_cycle", {63'd0, bus.stall}, 64'd0);
        step();
        bus.cancel = 1'b0;
        bus.div    = 1'b0;
        seen_done  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.div_done === 1'b1) seen_done = 1'b1;
        end
        check("cancel_no_done", {63'd0, seen_done}, 64'd0);
        check("cancel_hi_kept", {32'd0, bus.hi}, 64'd5);
        check("cancel_lo_kept", {32'd0, bus.lo}, 64'hFFFF_FFFF);
        $display("[TB] cancel at cycle 10 -> hi=%08h lo=%08h", bus.hi, bus.lo);

        // ---- next divide after cancel, with hilo_en=11 in DONE ----
        step();
        run_div("divu_9_4_en_done", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b1);

        // ---- MTLO, then a no-write code ----
        step();
        bus.src_a   = 32'h0000_1234;
        bus.hilo_en = 2'b00;
        step();
        bus.src_a   = 32'h0000_5555;
        bus.hilo_en = 2'b10;
        step();
        @(negedge clk);
        check("mtlo_lo", {32'd0, bus.lo}, 64'h0000_1234);
        check("mtlo_hi_kept", {32'd0, bus.hi}, 64'd1);
        $display("[TB] MTLO %08h -> hi=%08h lo=%08h", 32'h0000_1234, bus.hi, bus.lo);

        // ---- reset mid-BUSY ----
        step();
        bus.div     = 1'b1;
        bus.hassign = 1'b0;
        bus.src_a   = 32'd100;
        bus.src_b   = 32'd7;
        for (int c = 0; c < 5; c++) step();
        rst_n   = 1'b0;
        bus.div = 1'b0;
        step();
        @(negedge clk);
        check("midrst_hi", {32'd0, bus.hi}, 64'd0);
        check("midrst_lo", {32'd0, bus.lo}, 64'd0);
        check("midrst_stall", {63'd0, bus.stall}, 64'd0);
        check("midrst_div_done", {63'd0, bus.div_done}, 64'd0);
        $display("[TB] reset mid-division -> hi=%08h lo=%08h", bus.hi, bus.lo);
        step();
        rst_n = 1'b1;
        step();
        run_div("divu_after_rst", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hilo_div_unit.md
# hilo_div_unit

HI/LO register unit with an iterative 32-bit divider, sitting in the execute stage. It consumes the ALU decoder's `hilo_en`, `hilo_mf`, `div` and `hassign` controls. It writes HI/LO from MTHI/MTLO operands or the ALU's MULT product, and serves MFHI/MFLO reads. It runs a multi-cycle DIV/DIVU while stalling the pipeline.

## Interface
Parameters:
- `DIV_CYCLES`, 32: quotient bits produced, one per cycle; fixed at 32.

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `hilo_en`  in  2  11 write {HI,LO}←`prod`; 01 HI←`src_a`; 00 LO←`src_a`; 10 no write
- `hilo_mf`  in  2  01 `mf_data`=HI; 00 `mf_data`=LO; other values give 0
- `div`  in  1  divide request, held high by the pipeline while `stall` is high
- `hassign`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with `div`
- `src_a`  in  32  rs operand: dividend, or MTHI/MTLO data
- `src_b`  in  32  rt operand: divisor
- `prod`  in  64  MULT/MULTU product from the ALU, {HI,LO}
- `cancel`  in  1  exception flush; aborts any division in flight
- `stall`  out  1  pipeline stall request
- `div_done`  out  1  one-cycle pulse when the quotient/remainder write occurs
- `mf_data`  out  32  MFHI/MFLO read data, combinational
- `hi`, `lo`  out  32 each  current register values

## Operation
- States:
  - IDLE: accepts requests.
  - BUSY: 32 iterations in progress.
  - DONE: one cycle; commits the result.
- Transitions:
  - IDLE→BUSY when `div`=1 and `cancel`=0. Latch |a|, |b|, the signs and `hassign`.
  - BUSY→DONE after 32 iterations.
  - DONE→IDLE unconditionally.
  - Any state→IDLE when `cancel`=1. HI/LO are unchanged and there is no `div_done`.
- Operand handling: signed mode uses absolute values, with the MSB taken as the sign; unsigned mode uses the raw operands.
- Iteration: restoring radix-2 on a 64-bit {rem,quo} register. Shift left 1, trial-subtract the divisor from the upper 33 bits, and set the quotient LSB when the result is non-negative.
- Sign fix in DONE, signed mode only:
  - Negate the quotient if sign_a≠sign_b.
  - Negate the remainder if sign_a=1.
- Divide by zero: no fix applied. LO=0xFFFFFFFF, HI=`src_a` latched (the natural restoring result).
- Overflow, 0x80000000 / 0xFFFFFFFF signed: LO=0x80000000, HI=0 (falls out of the unsigned magnitude path).
- DONE cycle: HI←remainder, LO←quotient; `div_done`=1.
- `hilo_en` writes take effect at the edge in any state.
- Write priority: in the DONE cycle the divider write wins over `hilo_en` on the same edge.
- `mf_data` reads registered values only; there is no same-cycle bypass.
- Reset: HI=LO=0, state IDLE, counter 0. Outputs `stall`=0, `div_done`=0, `mf_data`=0 (`hilo_mf`=10 at reset from the decoder).

## Timing
- `stall` = `div` & ~(state==DONE) & ~`cancel`, combinational.
- Division timeline, with cycle 0 = first cycle `div`=1 in IDLE:
  - Cycles 0..32: `stall`=1.
  - Cycle 33: DONE, `stall`=0, `div_done`=1.
  - Cycle 34 onward: HI/LO hold the new values.
- Total stall: 33 cycles.
- Operands are latched at the cycle-0 edge. Changes to `src_a`/`src_b` after that are ignored.
- `div` high in DONE belongs to the same instruction and does not restart.
- Back-to-back divides: the next instruction's `div` is seen in IDLE at cycle 34 and starts a fresh division.
- `cancel` in cycle 0 prevents the start.
- `cancel` mid-BUSY: IDLE on the next edge; `stall` drops in the same cycle.
- Reset mid-division: IDLE on the next edge. HI/LO clear to 0.
- `hilo_en`/`prod` writes are visible on `hi`/`lo` and `mf_data` in the cycle after the edge.

## Structure
- Package `hilo_pkg` holds:
  - `hilo_en` codes: EN_LO=00, EN_HI=01, EN_NONE=10, EN_BOTH=11.
  - `hilo_mf` codes: MF_LO=00, MF_HI=01.
  - State enum: IDLE/BUSY/DONE.
  - `DIV_CYCLES`.
- Sub-module `div_core` contains the iteration register, counter and sign fix, and exposes start/cancel/done.
- The top level keeps HI/LO, the write-priority mux, the read mux and the stall logic.

## Test plan
- DIVU 100/7 → 33 stall cycles, `div_done` at cycle 33, then LO=14, HI=2.
- DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
- MULT write with `prod`=0x00000001_00000002, `hilo_en`=11 → HI=1, LO=2. Then MTHI 0xDEAD, `hilo_en`=01 → HI=0xDEAD, LO unchanged. MFHI/MFLO return 0xDEAD/2.
- `cancel` at cycle 10 of a division → `stall` low the same cycle, no `div_done`, HI/LO keep their old values. The next `div` starts cleanly.
- `hilo_en`=11 in the DONE cycle of DIVU 9/4 → LO=2, HI=1 (the divider wins). `rst_n`=0 mid-BUSY → HI=LO=0, `stall`=0.
